// File: rtl/addsub_seq_ctrl_pkg.sv
// Shared types and constants for the add/sub operator sequencer.
// Holds the FSM encoding, display-source codes and result-flag layout.
package addsub_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    SETTLE  = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [1:0] DISP_OP1 = 2'd0;
  localparam logic [1:0] DISP_OP2 = 2'd1;
  localparam logic [1:0] DISP_RES = 2'd2;

  localparam int FLAG_SIGN  = 2;
  localparam int FLAG_OVER  = 1;
  localparam int FLAG_CARRY = 0;

  // Place the three datapath flags at their fixed res_flags positions.
  function automatic logic [2:0] pack_flags(input logic sign, input logic over, input logic carry);
    logic [2:0] f;
    f             = 3'b000;
    f[FLAG_SIGN]  = sign;
    f[FLAG_OVER]  = over;
    f[FLAG_CARRY] = carry;
    return f;
  endfunction

endpackage

// File: rtl/addsub_seq_ctrl_if.sv
// Byte-slot bus between the sequencer (master) and the add/sub datapath (slave).
interface addsub_seq_ctrl_if;
  logic [7:0]  byte_out;
  logic [1:0]  counter;
  logic        fstorsnd;
  logic        addorsub;
  logic [31:0] dp_sum;
  logic        dp_carry;
  logic        dp_over;
  logic        dp_sign;

  modport master (
    output byte_out, counter, fstorsnd, addorsub,
    input  dp_sum, dp_carry, dp_over, dp_sign
  );

  modport slave (
    input  byte_out, counter, fstorsnd, addorsub,
    output dp_sum, dp_carry, dp_over, dp_sign
  );
endinterface

// File: rtl/addsub_seq_ctrl_btn_pulse.sv
// Button conditioner: two-flop synchronizer, level debounce, one-cycle pulse
// on each accepted rising edge (DEB_CYCLES+3 cycles after the raw level settles).
module btn_pulse #(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int DEB_W      = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic pulse
);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_ZERO = {DEB_W{1'b0}};
  localparam logic [DEB_W-1:0] DEB_ONE  = {{(DEB_W-1){1'b0}}, 1'b1};

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic             level_d_r;
  logic             pulse_r;
  logic [DEB_W-1:0] deb_cnt_r;

  // Bring the raw button into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn_raw;
      sync2_r <= sync1_r;
    end
  end

  // Accept a new level only after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_r   <= 1'b0;
      deb_cnt_r <= DEB_ZERO;
    end else if (sync2_r == level_r) begin
      deb_cnt_r <= DEB_ZERO;
    end else if (deb_cnt_r == DEB_LAST) begin
      level_r   <= sync2_r;
      deb_cnt_r <= DEB_ZERO;
    end else begin
      deb_cnt_r <= deb_cnt_r + DEB_ONE;
    end
  end

  // Registered rising-edge detect on the accepted level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_d_r <= 1'b0;
      pulse_r   <= 1'b0;
    end else begin
      level_d_r <= level_r;
      pulse_r   <= level_r & ~level_d_r;
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/addsub_seq_ctrl.sv
// Operator sequencer: steers switch bytes into datapath slots, freezes the bus
// while the datapath settles, then captures result and flags for display.
module addsub_seq_ctrl
  import addsub_seq_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES    = 1_000_000,
  parameter int DEB_W         = 20,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            sw_data,
  input  logic                  sw_sub,
  input  logic                  btn_next,
  input  logic                  btn_clear,
  addsub_seq_ctrl_if.master     dp,
  output logic [31:0]           res_sum,
  output logic [2:0]            res_flags,
  output logic                  done,
  output logic [1:0]            disp_sel
);

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  logic        next_pulse_s;
  logic        clear_pulse_s;

  state_t      state_r,     state_nx_s;
  logic [1:0]  counter_r,   counter_nx_s;
  logic        fstorsnd_r,  fstorsnd_nx_s;
  logic [7:0]  byte_r,      byte_nx_s;
  logic        addorsub_r,  addorsub_nx_s;
  logic [31:0] res_sum_r,   res_sum_nx_s;
  logic [2:0]  res_flags_r, res_flags_nx_s;
  logic        done_r,      done_nx_s;
  logic [1:0]  disp_sel_r,  disp_sel_nx_s;
  logic [7:0]  settle_r,    settle_nx_s;

  btn_pulse #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_next (
    .clk(clk), .rst(rst), .btn_raw(btn_next), .pulse(next_pulse_s)
  );

  btn_pulse #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_clear (
    .clk(clk), .rst(rst), .btn_raw(btn_clear), .pulse(clear_pulse_s)
  );

  // State and every output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ENTER_A;
      counter_r   <= 2'd0;
      fstorsnd_r  <= 1'b0;
      byte_r      <= 8'd0;
      addorsub_r  <= 1'b0;
      res_sum_r   <= 32'd0;
      res_flags_r <= 3'b000;
      done_r      <= 1'b0;
      disp_sel_r  <= DISP_OP1;
      settle_r    <= 8'd0;
    end else begin
      state_r     <= state_nx_s;
      counter_r   <= counter_nx_s;
      fstorsnd_r  <= fstorsnd_nx_s;
      byte_r      <= byte_nx_s;
      addorsub_r  <= addorsub_nx_s;
      res_sum_r   <= res_sum_nx_s;
      res_flags_r <= res_flags_nx_s;
      done_r      <= done_nx_s;
      disp_sel_r  <= disp_sel_nx_s;
      settle_r    <= settle_nx_s;
    end
  end

  // Next-state selection; clear overrides everything, including a same-cycle next.
  always_comb begin
    state_nx_s = state_r;
    if (clear_pulse_s) begin
      state_nx_s = ENTER_A;
    end else begin
      case (state_r)
        ENTER_A: if (next_pulse_s && counter_r == 2'd3) state_nx_s = ENTER_B;
                 else                                   state_nx_s = ENTER_A;
        ENTER_B: if (next_pulse_s && counter_r == 2'd3) state_nx_s = SETTLE;
                 else                                   state_nx_s = ENTER_B;
        SETTLE:  if (settle_r == 8'd0)                  state_nx_s = DONE;
                 else                                   state_nx_s = SETTLE;
        DONE:    if (next_pulse_s)                      state_nx_s = ENTER_A;
                 else                                   state_nx_s = DONE;
        default: state_nx_s = ENTER_A;
      endcase
    end
  end

  // Register next values; byte_out/addorsub only track the switches during entry.
  always_comb begin
    counter_nx_s   = counter_r;
    fstorsnd_nx_s  = fstorsnd_r;
    byte_nx_s      = byte_r;
    addorsub_nx_s  = addorsub_r;
    res_sum_nx_s   = res_sum_r;
    res_flags_nx_s = res_flags_r;
    done_nx_s      = done_r;
    disp_sel_nx_s  = disp_sel_r;
    settle_nx_s    = settle_r;
    if (clear_pulse_s) begin
      counter_nx_s   = 2'd0;
      fstorsnd_nx_s  = 1'b0;
      byte_nx_s      = sw_data;
      addorsub_nx_s  = sw_sub;
      res_sum_nx_s   = 32'd0;
      res_flags_nx_s = 3'b000;
      done_nx_s      = 1'b0;
      disp_sel_nx_s  = DISP_OP1;
      settle_nx_s    = 8'd0;
    end else begin
      case (state_r)
        ENTER_A: begin
          byte_nx_s     = sw_data;
          addorsub_nx_s = sw_sub;
          disp_sel_nx_s = DISP_OP1;
          if (next_pulse_s) begin
            if (counter_r == 2'd3) begin
              counter_nx_s  = 2'd0;
              fstorsnd_nx_s = 1'b1;
              disp_sel_nx_s = DISP_OP2;
            end else begin
              counter_nx_s  = counter_r + 2'd1;
            end
          end else begin
            counter_nx_s = counter_r;
          end
        end
        ENTER_B: begin
          byte_nx_s     = sw_data;
          addorsub_nx_s = sw_sub;
          disp_sel_nx_s = DISP_OP2;
          if (next_pulse_s) begin
            if (counter_r == 2'd3) begin
              settle_nx_s  = SETTLE_LOAD;
            end else begin
              counter_nx_s = counter_r + 2'd1;
            end
          end else begin
            counter_nx_s = counter_r;
          end
        end
        SETTLE: begin
          if (settle_r == 8'd0) begin
            res_sum_nx_s   = dp.dp_sum;
            res_flags_nx_s = pack_flags(dp.dp_sign, dp.dp_over, dp.dp_carry);
            done_nx_s      = 1'b1;
            disp_sel_nx_s  = DISP_RES;
          end else begin
            settle_nx_s    = settle_r - 8'd1;
          end
        end
        DONE: begin
          if (next_pulse_s) begin
            counter_nx_s  = 2'd0;
            fstorsnd_nx_s = 1'b0;
            done_nx_s     = 1'b0;
            disp_sel_nx_s = DISP_OP1;
          end else begin
            done_nx_s     = done_r;
          end
        end
        default: begin
          counter_nx_s  = 2'd0;
          fstorsnd_nx_s = 1'b0;
          done_nx_s     = 1'b0;
          disp_sel_nx_s = DISP_OP1;
        end
      endcase
    end
  end

  assign dp.byte_out = byte_r;
  assign dp.counter  = counter_r;
  assign dp.fstorsnd = fstorsnd_r;
  assign dp.addorsub = addorsub_r;
  assign res_sum     = res_sum_r;
  assign res_flags   = res_flags_r;
  assign done        = done_r;
  assign disp_sel    = disp_sel_r;

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Directed bench for addsub_seq_ctrl with a transparent-slot datapath model.
module tb_addsub_seq_ctrl;
  import addsub_seq_ctrl_pkg::*;

  localparam int DEB = 4;
  localparam int DEBW = 3;
  localparam int SET = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  sw_data;
  logic        sw_sub;
  logic        btn_next;
  logic        btn_clear;
  logic [31:0] res_sum;
  logic [2:0]  res_flags;
  logic        done;
  logic [1:0]  disp_sel;

  int errors = 0;
  int checks = 0;

  addsub_seq_ctrl_if bus ();

  addsub_seq_ctrl #(.DEB_CYCLES(DEB), .DEB_W(DEBW), .SETTLE_CYCLES(SET)) dut (
    .clk(clk), .rst(rst), .sw_data(sw_data), .sw_sub(sw_sub),
    .btn_next(btn_next), .btn_clear(btn_clear), .dp(bus),
    .res_sum(res_sum), .res_flags(res_flags), .done(done), .disp_sel(disp_sel)
  );

  always #5 clk = ~clk;

  // Datapath model: slot addressed by {fstorsnd,counter} follows byte_out.
  logic [7:0]  slot [0:7];
  logic [31:0] op_a, op_b;
  logic [32:0] add_w;
  initial for (int i = 0; i < 8; i++) slot[i] = 8'd0;
  always @(posedge clk) slot[{bus.fstorsnd, bus.counter}] <= bus.byte_out;

  always_comb begin
    op_a  = {slot[3], slot[2], slot[1], slot[0]};
    op_b  = {slot[7], slot[6], slot[5], slot[4]};
    add_w = {1'b0, op_a} + {1'b0, op_b};
    if (!bus.addorsub) begin
      bus.dp_sum   = add_w[31:0];
      bus.dp_carry = add_w[32];
      bus.dp_over  = (op_a[31] == op_b[31]) && (add_w[31] != op_a[31]);
      bus.dp_sign  = add_w[31];
    end else if (op_a >= op_b) begin
      bus.dp_sum   = op_a - op_b;
      bus.dp_carry = 1'b0;
      bus.dp_over  = 1'b0;
      bus.dp_sign  = 1'b0;
    end else begin
      bus.dp_sum   = op_b - op_a;
      bus.dp_carry = 1'b1;
      bus.dp_over  = 1'b0;
      bus.dp_sign  = 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic nxt, input logic clr);
    btn_next  = nxt;
    btn_clear = clr;
    tick(DEB + 6);
    btn_next  = 1'b0;
    btn_clear = 1'b0;
    tick(DEB + 6);
  endtask

  task automatic enter_byte(input logic [7:0] v);
    sw_data = v;
    tick(2);
    press(1'b1, 1'b0);
  endtask

  // Enter all of operand A and the first three bytes of B, leave B's top byte on the switches.
  task automatic enter_operands(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 4; i++) enter_byte(a[8*i +: 8]);
    for (int i = 0; i < 3; i++) enter_byte(b[8*i +: 8]);
    sw_data = b[31:24];
    tick(2);
  endtask

  task automatic wait_settle_entry();
    int n;
    n = 0;
    btn_next = 1'b1;
    while (dut.state_r != SETTLE && n < 40) begin
      tick(1);
      n++;
    end
    check_eq("settle_entry", 32'(dut.state_r), 32'(SETTLE));
    btn_next = 1'b0;
  endtask

  task automatic finish_entry();
    int n;
    wait_settle_entry();
    n = 0;
    while (!done && n < 40) begin
      tick(1);
      n++;
    end
    check_eq("settle_latency", 32'(n), 32'(SET));
    tick(DEB + 6);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; sw_data = 8'd0; sw_sub = 1'b0; btn_next = 1'b0; btn_clear = 1'b0;
    tick(3);
    check_eq("rst_counter",  32'(bus.counter),  32'd0);
    check_eq("rst_fstorsnd", 32'(bus.fstorsnd), 32'd0);
    check_eq("rst_byte",     32'(bus.byte_out), 32'd0);
    check_eq("rst_res_sum",  res_sum,           32'd0);
    check_eq("rst_flags",    32'(res_flags),    32'd0);
    check_eq("rst_done",     32'(done),         32'd0);
    check_eq("rst_disp",     32'(disp_sel),     32'd0);
    rst = 1'b0;
    tick(2);

    // Addition 0x12345678 + 1
    enter_operands(32'h1234_5678, 32'h0000_0001);
    check_eq("b_counter",  32'(bus.counter),  32'd3);
    check_eq("b_fstorsnd", 32'(bus.fstorsnd), 32'd1);
    check_eq("b_disp",     32'(disp_sel),     32'd1);
    finish_entry();
    check_eq("add_done",  32'(done),      32'd1);
    check_eq("add_sum",   res_sum,        32'h1234_5679);
    check_eq("add_flags", 32'(res_flags), 32'd0);
    check_eq("add_disp",  32'(disp_sel),  32'd2);

    // Leave DONE: result retained
    press(1'b1, 1'b0);
    check_eq("exit_state",   32'(dut.state_r),  32'(ENTER_A));
    check_eq("exit_counter", 32'(bus.counter),  32'd0);
    check_eq("exit_fst",     32'(bus.fstorsnd), 32'd0);
    check_eq("exit_done",    32'(done),         32'd0);
    check_eq("exit_sum",     res_sum,           32'h1234_5679);

    // Subtraction 5 - 9 reported as magnitude 4, negative
    sw_sub = 1'b1;
    enter_operands(32'h0000_0005, 32'h0000_0009);
    finish_entry();
    check_eq("sub_sum",   res_sum,        32'h0000_0004);
    check_eq("sub_flags", 32'(res_flags), 32'h5);
    sw_sub = 1'b0;
    sw_data = 8'hAA;
    tick(5);
    check_eq("frz_addorsub", 32'(bus.addorsub), 32'd1);
    check_eq("frz_byte",     32'(bus.byte_out), 32'd0);
    check_eq("frz_sum",      res_sum,           32'h0000_0004);
    press(1'b1, 1'b0);
    check_eq("ret_flags", 32'(res_flags), 32'h5);

    // Bouncy next: glitches ignored, stable press counted once
    for (int g = 0; g < 5; g++) begin
      btn_next = 1'b1; tick(2);
      btn_next = 1'b0; tick(2);
    end
    tick(DEB + 4);
    check_eq("glitch_counter", 32'(bus.counter), 32'd0);
    btn_next = 1'b1; tick(10);
    btn_next = 1'b0; tick(DEB + 6);
    check_eq("bounce_counter", 32'(bus.counter), 32'd1);

    // Reach ENTER_B counter 2, then clear and next together
    for (int p = 0; p < 5; p++) press(1'b1, 1'b0);
    check_eq("pre_clr_counter", 32'(bus.counter),  32'd2);
    check_eq("pre_clr_fst",     32'(bus.fstorsnd), 32'd1);
    press(1'b1, 1'b1);
    check_eq("clr_state",   32'(dut.state_r),  32'(ENTER_A));
    check_eq("clr_counter", 32'(bus.counter),  32'd0);
    check_eq("clr_fst",     32'(bus.fstorsnd), 32'd0);
    check_eq("clr_sum",     res_sum,           32'd0);
    check_eq("clr_flags",   32'(res_flags),    32'd0);
    check_eq("clr_disp",    32'(disp_sel),     32'd0);

    // Reset three cycles into SETTLE: no capture
    enter_operands(32'h1234_5678, 32'h0000_0001);
    wait_settle_entry();
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(SET + 10);
    check_eq("rstset_done",    32'(done),         32'd0);
    check_eq("rstset_sum",     res_sum,           32'd0);
    check_eq("rstset_state",   32'(dut.state_r),  32'(ENTER_A));
    check_eq("rstset_counter", 32'(bus.counter),  32'd0);
    check_eq("rstset_fst",     32'(bus.fstorsnd), 32'd0);

    // Full re-entry after reset
    enter_operands(32'h1234_5678, 32'h0000_0001);
    finish_entry();
    check_eq("re_done", 32'(done), 32'd1);
    check_eq("re_sum",  res_sum,   32'h1234_5679);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/addsub_seq_ctrl.md
Name: addsub_seq_ctrl

Overview:
- Operator-facing sequencer for the 32-bit add/sub datapath on the lab board.
- Turns one 8-bit switch bank plus two push buttons into the byte-slot steering the datapath expects: `counter`, `fstorsnd`, byte data and `addorsub`.
- Waits a fixed settle time, then captures the result and flags into holding registers that drive the display.
- Sits between the board I/O (switches, buttons, LEDs, seven-segment mux) and the add/sub datapath.

Parameters:
- DEB_CYCLES, 1_000_000, stable-level cycles needed to accept a button press (set to 4 in simulation).
- DEB_W, 20, width of the debounce counter; must satisfy 2^DEB_W > DEB_CYCLES.
- SETTLE_CYCLES, 8, cycles waited after operand entry before the result is captured (range 1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- sw_data  in  8  byte value on the switches.
- sw_sub  in  1  operation switch: 0 = add, 1 = subtract.
- btn_next  in  1  raw, bouncy button: advance one byte slot.
- btn_clear  in  1  raw, bouncy button: abort and restart entry.
- dp_sum  in  32  datapath sum.
- dp_carry  in  1  datapath carry.
- dp_over  in  1  datapath overflow.
- dp_sign  in  1  datapath sign (result negative).
- byte_out  out  8  byte driven to the datapath input.
- counter  out  2  byte slot index.
- fstorsnd  out  1  operand select: 0 = first, 1 = second.
- addorsub  out  1  operation sent to the datapath.
- res_sum  out  32  captured result.
- res_flags  out  3  captured {sign, over, carry}.
- done  out  1  result valid.
- disp_sel  out  2  display source: 0 = operand1, 1 = operand2, 2 = result.

Behaviour:
- Async reset values: state=ENTER_A; counter=0; fstorsnd=0; byte_out=0; addorsub=0; res_sum=0; res_flags=0; done=0; disp_sel=0; settle counter=0.
- Button conditioning (btn_pulse instances):
  - Two-flop synchronizer, then debounce: the level is accepted after DEB_CYCLES consecutive equal samples.
  - One-cycle pulse on each accepted 0→1 edge.
  - Pulse latency after the raw level settles: DEB_CYCLES+3 cycles.
  - A held button yields exactly one pulse.
- FSM states and transitions:
  - ENTER_A: byte_out=sw_data (registered, 1-cycle lag); addorsub=sw_sub; disp_sel=0.
    - next pulse with counter<3: counter+1.
    - next pulse with counter==3: go to ENTER_B with counter=0, fstorsnd=1.
  - ENTER_B: same as ENTER_A with disp_sel=1.
    - next pulse with counter==3: go to SETTLE. byte_out and addorsub freeze. Settle counter loads SETTLE_CYCLES-1.
  - SETTLE: counter stays 3, fstorsnd stays 1, outputs frozen; settle counter decrements each cycle.
    - When it reaches 0: capture dp_sum→res_sum and {dp_sign,dp_over,dp_carry}→res_flags; done=1; disp_sel=2; go to DONE.
  - DONE: all outputs held.
    - next pulse: go to ENTER_A, counter=0, fstorsnd=0, done=0. res_sum and res_flags are retained until the next capture.
- Clear pulse in any state: go to ENTER_A, counter=0, fstorsnd=0, done=0, res_sum=0, res_flags=0, disp_sel=0.
  - Clear and next pulsing in the same cycle: clear wins.
- Result latency: the capture edge comes SETTLE_CYCLES clocks after the SETTLE-entry edge.
- Freezing is mandatory. The datapath slot registers are transparent to whichever slot `counter` addresses, so byte_out must not follow the switches outside ENTER_A/ENTER_B.
- Changing sw_sub during SETTLE or DONE has no effect.
- Reset asserted mid-entry or mid-settle: immediate return to the reset values, with no capture.
- counter never wraps on its own; it returns to 0 only on an operand transition, on clear, or on leaving DONE.

Decomposition:
- Shared package/header holds:
  - State encoding: ENTER_A=2'd0, ENTER_B=2'd1, SETTLE=2'd2, DONE=2'd3.
  - disp_sel codes: DISP_OP1=0, DISP_OP2=1, DISP_RES=2.
  - res_flags bit indices: SIGN=2, OVER=1, CARRY=0.
- Sub-module btn_pulse (synchronizer + debounce + rising-edge pulse, parameterised by DEB_CYCLES/DEB_W), instantiated twice.
- FSM, freeze logic and result capture live in the top module.

Test Plan:
- Reset, then 8 clean next presses with sw_data = 0x78,0x56,0x34,0x12,0x01,0x00,0x00,0x00 and sw_sub=0, datapath model attached → done=1 after SETTLE_CYCLES, res_sum=0x12345679, res_flags=3'b000, disp_sel=2.
- Subtract with sw_sub=1, operand1=0x00000005, operand2=0x00000009 → res_sum=0x00000004, res_flags[2]=1; toggling sw_sub and sw_data in DONE leaves addorsub, byte_out and res_sum unchanged.
- Bouncy btn_next (5 glitches shorter than DEB_CYCLES, then stable high for 10 cycles) → exactly one counter increment.
- Clear asserted in the same cycle as next while in ENTER_B counter=2 → ENTER_A, counter=0, fstorsnd=0, res_sum=0.
- Reset asserted 3 cycles into SETTLE → done stays 0, res_sum=0, state=ENTER_A; a full re-entry then completes normally.
- In DONE with res_sum=0x12345679, a next press → ENTER_A, counter=0, done=0, res_sum still 0x12345679.
